// File: rtl/lenet_pkg.sv
// Shared LeNet front-end definitions: default pixel width, image geometry and pixel type.
package lenet_pkg;

  localparam int BIT_WIDTH = 8;
  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int COL_W     = $clog2(IMG_W);
  localparam int ROW_W     = $clog2(IMG_H);

  typedef logic signed [BIT_WIDTH-1:0] pix_t;

endpackage

// File: rtl/line_delay.sv
// Enable-gated circular buffer: dout is the sample written DEPTH enabled cycles earlier.
module line_delay #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic signed [BIT_WIDTH-1:0] din,
  output logic signed [BIT_WIDTH-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [BIT_WIDTH-1:0] mem_q [DEPTH];
  logic signed [BIT_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]            ptr_q, ptr_d;

  // Read happens before the overwrite at the same slot, giving exactly DEPTH samples of delay.
  assign dout = mem_q[ptr_q];

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (en) begin
      mem_d[ptr_q] = din;
      ptr_d        = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 stride-1 sliding window. Optional CONV_WIN_COORD_EN adds the
// output-map coordinate (win_row, win_col) of each window.
module conv_window_gen #(
  parameter int BIT_WIDTH = lenet_pkg::BIT_WIDTH,
  parameter int IMG_W     = lenet_pkg::IMG_W,
  parameter int IMG_H     = lenet_pkg::IMG_H
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic signed [BIT_WIDTH-1:0] pix_in,
  output logic signed [BIT_WIDTH-1:0] win1,
  output logic signed [BIT_WIDTH-1:0] win2,
  output logic signed [BIT_WIDTH-1:0] win3,
  output logic signed [BIT_WIDTH-1:0] win4,
  output logic signed [BIT_WIDTH-1:0] win5,
  output logic signed [BIT_WIDTH-1:0] win6,
  output logic signed [BIT_WIDTH-1:0] win7,
  output logic signed [BIT_WIDTH-1:0] win8,
  output logic signed [BIT_WIDTH-1:0] win9,
`ifdef CONV_WIN_COORD_EN
  output logic [$clog2(IMG_H)-1:0]    win_row,
  output logic [$clog2(IMG_W)-1:0]    win_col,
`endif
  output logic                        win_valid,
  output logic                        frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  // Handshake: pix_valid qualifies pix_in and every valid pixel is consumed (no ready);
  // win_valid qualifies win1..win9 for exactly one cycle and cannot be stalled.
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic signed [BIT_WIDTH-1:0] sh_q  [9];
  logic signed [BIT_WIDTH-1:0] sh_d  [9];
  logic signed [BIT_WIDTH-1:0] win_q [9];
  logic signed [BIT_WIDTH-1:0] win_d [9];
  logic win_valid_q, win_valid_d;
  logic frame_done_q, frame_done_d;
  logic signed [BIT_WIDTH-1:0] line1_out, line2_out;
`ifdef CONV_WIN_COORD_EN
  logic [ROW_W-1:0] wrow_q, wrow_d;
  logic [COL_W-1:0] wcol_q, wcol_d;
`endif

  line_delay #(.BIT_WIDTH(BIT_WIDTH), .DEPTH(IMG_W)) u_line1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pix_valid),
    .din  (pix_in),
    .dout (line1_out)
  );

  line_delay #(.BIT_WIDTH(BIT_WIDTH), .DEPTH(IMG_W)) u_line2 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pix_valid),
    .din  (line1_out),
    .dout (line2_out)
  );

  always_comb begin
    cur_col      = frame_start ? '0 : col_q;
    cur_row      = frame_start ? '0 : row_q;
    col_d        = cur_col;
    row_d        = cur_row;
    sh_d         = sh_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef CONV_WIN_COORD_EN
    wrow_d = wrow_q;
    wcol_d = wcol_q;
`endif
    if (pix_valid) begin
      if (cur_col == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
      end
      // Row-major 3x3: shift left, new right column comes from the two delay lines and the input.
      for (int i = 0; i < 3; i++) begin
        sh_d[3*i]   = sh_q[3*i+1];
        sh_d[3*i+1] = sh_q[3*i+2];
      end
      sh_d[2] = line2_out;
      sh_d[5] = line1_out;
      sh_d[8] = pix_in;
      win_valid_d  = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      frame_done_d = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
      if (win_valid_d) begin
        win_d = sh_d;
`ifdef CONV_WIN_COORD_EN
        wrow_d = cur_row - ROW_W'(2);
        wcol_d = cur_col - COL_W'(2);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        sh_q[i]  <= '0;
        win_q[i] <= '0;
      end
`ifdef CONV_WIN_COORD_EN
      wrow_q <= '0;
      wcol_q <= '0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 9; i++) begin
        sh_q[i]  <= sh_d[i];
        win_q[i] <= win_d[i];
      end
`ifdef CONV_WIN_COORD_EN
      wrow_q <= wrow_d;
      wcol_q <= wcol_d;
`endif
    end
  end

  assign win1       = win_q[0];
  assign win2       = win_q[1];
  assign win3       = win_q[2];
  assign win4       = win_q[3];
  assign win5       = win_q[4];
  assign win6       = win_q[5];
  assign win7       = win_q[6];
  assign win8       = win_q[7];
  assign win9       = win_q[8];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
`ifdef CONV_WIN_COORD_EN
  assign win_row = wrow_q;
  assign win_col = wcol_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen against an image-array reference model.
// Define CONV_WIN_COORD_EN to also check win_row/win_col.
module tb_conv_window_gen;
  import lenet_pkg::*;

  localparam int W    = 2 + 9 * BIT_WIDTH;
  localparam int CW   = ROW_W + COL_W;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NWIN = (IMG_W - 2) * (IMG_H - 2);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_start = 1'b0;
  logic pix_valid = 1'b0;
  pix_t pix_in = '0;
  pix_t win1, win2, win3, win4, win5, win6, win7, win8, win9;
  logic win_valid, frame_done;
`ifdef CONV_WIN_COORD_EN
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
`endif

  always #5 clk = ~clk;

  conv_window_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .win1       (win1),
    .win2       (win2),
    .win3       (win3),
    .win4       (win4),
    .win5       (win5),
    .win6       (win6),
    .win7       (win7),
    .win8       (win8),
    .win9       (win9),
`ifdef CONV_WIN_COORD_EN
    .win_row    (win_row),
    .win_col    (win_col),
`endif
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] expc_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_win = 0;
  int n_done = 0;
  logic [9*BIT_WIDTH-1:0] first_win = '0;
  bit first_seen = 1'b0;

  // Reference model: the frame as a 2-D array, position derived from the accepted-pixel count.
  logic [BIT_WIDTH-1:0]   img [IMG_H][IMG_W];
  int                     m_idx = 0;
  logic [9*BIT_WIDTH-1:0] m_win = '0;
  logic [ROW_W-1:0]       m_row = '0;
  logic [COL_W-1:0]       m_col = '0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {win_valid, frame_done, win1, win2, win3, win4, win5, win6, win7, win8, win9};
  endfunction

  task automatic model_push(input logic [BIT_WIDTH-1:0] pix, input logic pv, input logic fs);
    int r, c;
    logic v, d;
    v = 1'b0;
    d = 1'b0;
    if (fs) m_idx = 0;
    if (pv) begin
      r = m_idx / IMG_W;
      c = m_idx % IMG_W;
      img[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        v = 1'b1;
        m_win = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                 img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                 img[r][c-2],   img[r][c-1],   img[r][c]};
        m_row = ROW_W'(r - 2);
        m_col = COL_W'(c - 2);
      end
      d = (r == IMG_H - 1) && (c == IMG_W - 1);
      m_idx = (m_idx + 1) % NPIX;
    end
    exp_q.push_back({v, d, m_win});
    expc_q.push_back({m_row, m_col});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [BIT_WIDTH-1:0] pix, input logic pv, input logic fs);
    logic [W-1:0]  e;
    logic [CW-1:0] ec;
    pix_in      = pix;
    pix_valid   = pv;
    frame_start = fs;
    model_push(pix, pv, fs);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    ec = expc_q.pop_front();
    check_eq("window", dut_vec(), e);
`ifdef CONV_WIN_COORD_EN
    check_eq("coord", {win_row, win_col}, ec);
`else
    if (ec === 'x) $display("note: coordinate model undefined");
`endif
    if (win_valid) begin
      n_win++;
      if (!first_seen) begin
        first_win  = {win1, win2, win3, win4, win5, win6, win7, win8, win9};
        first_seen = 1'b1;
      end
    end
    if (frame_done) n_done++;
  endtask

  function automatic logic [BIT_WIDTH-1:0] gen_pix(input int mode, input int idx);
    return (mode == 0) ? BIT_WIDTH'(idx % 128) : BIT_WIDTH'($urandom_range(0, 255));
  endfunction

  // Feeds npix pixels of a frame; bubble_pct is the chance of an idle cycle before each pixel.
  task automatic run_pixels(input int mode, input int npix, input int bubble_pct, input bit fs_first);
    for (int idx = 0; idx < npix; idx++) begin
      while (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) step('0, 1'b0, 1'b0);
      step(gen_pix(mode, idx), 1'b1, fs_first && (idx == 0));
    end
    step('0, 1'b0, 1'b0);
  endtask

  localparam logic [71:0] RAMP_FIRST = 72'h0001021C1D1E38393A;

  // ---------------- test sequence ----------------
  initial begin
    int w0, d0;
    #1 rst_n = 1'b0;
    #11;
    check_eq("reset_outputs", dut_vec(), '0);
`ifdef CONV_WIN_COORD_EN
    check_eq("reset_coord", {win_row, win_col}, '0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: ramp frame, no bubbles
    w0 = n_win; d0 = n_done; first_seen = 1'b0;
    run_pixels(0, NPIX, 0, 1'b0);
    check_eq("t1_win_count", 128'(n_win - w0), 128'(NWIN));
    check_eq("t1_done_count", 128'(n_done - d0), 128'd1);
    check_eq("t1_first_win", 128'(first_win), 128'(RAMP_FIRST));

    // 2: ramp frame with idle bubbles
    w0 = n_win; d0 = n_done;
    run_pixels(0, NPIX, 25, 1'b0);
    check_eq("t2_win_count", 128'(n_win - w0), 128'(NWIN));
    check_eq("t2_done_count", 128'(n_done - d0), 128'd1);

    // 3: two back-to-back random frames
    w0 = n_win; d0 = n_done;
    for (int idx = 0; idx < 2 * NPIX; idx++) begin
      step(gen_pix(1, idx), 1'b1, 1'b0);
      if (idx == NPIX - 1) begin
        check_eq("t3_done_at_first", 128'(n_done - d0), 128'd1);
        check_eq("t3_win_at_first", 128'(n_win - w0), 128'(NWIN));
      end
    end
    step('0, 1'b0, 1'b0);
    check_eq("t3_done_count", 128'(n_done - d0), 128'd2);
    check_eq("t3_win_count", 128'(n_win - w0), 128'(2 * NWIN));

    // 4: abandon a frame at (10,5) with frame_start alone, then a full frame
    run_pixels(0, 10 * IMG_W + 5, 0, 1'b0);
    step('0, 1'b0, 1'b1);
    check_eq("t4_fs_no_valid", 128'(win_valid), 128'd0);
    w0 = n_win; d0 = n_done;
    run_pixels(0, NPIX, 0, 1'b0);
    check_eq("t4_win_count", 128'(n_win - w0), 128'(NWIN));
    check_eq("t4_done_count", 128'(n_done - d0), 128'd1);

    // 5: asynchronous reset mid-frame at (15,15)
    run_pixels(1, 15 * IMG_W + 15, 0, 1'b0);
    pix_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_async_reset", dut_vec(), '0);
`ifdef CONV_WIN_COORD_EN
    check_eq("t5_async_coord", {win_row, win_col}, '0);
`endif
    pix_valid = 1'b0;
    m_idx = 0; m_win = '0; m_row = '0; m_col = '0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    w0 = n_win; d0 = n_done; first_seen = 1'b0;
    run_pixels(0, NPIX, 0, 1'b0);
    check_eq("t5_win_count", 128'(n_win - w0), 128'(NWIN));
    check_eq("t5_done_count", 128'(n_done - d0), 128'd1);
    check_eq("t5_first_win", 128'(first_win), 128'(RAMP_FIRST));

    // 6: random frame started with frame_start+pix_valid mid-frame, light bubbles
    run_pixels(1, 7 * IMG_W + 3, 0, 1'b0);
    w0 = n_win; d0 = n_done;
    run_pixels(1, NPIX, 10, 1'b1);
    check_eq("t6_win_count", 128'(n_win - w0), 128'(NWIN));
    check_eq("t6_done_count", 128'(n_done - d0), 128'd1);
`ifdef CONV_WIN_COORD_EN
    check_eq("t6_last_coord", 128'({win_row, win_col}), 128'({ROW_W'(IMG_H - 3), COL_W'(IMG_W - 3)}));
`endif
    check_eq("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
